// File: rtl/xf100_exu_disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xf100_exu_disp_pkg : shared widths, staged payload type, index decode helper
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef XF100_EXU_DEFINES
`define XF100_EXU_DEFINES
`define XF100_RFIDX_WIDTH 5
`define ALU_INFO_WIDTH 8
`define XF100_NUM_REGS 32
`endif

package xf100_exu_disp_pkg;

  localparam int RFIDX_W      = `XF100_RFIDX_WIDTH;
  localparam int ALU_INFO_W   = `ALU_INFO_WIDTH;
  localparam int NUM_REGS_DEF = `XF100_NUM_REGS;
  localparam int IDX_OH_W     = 1 << RFIDX_W;

  typedef struct packed {
    logic                  alu_op;
    logic [ALU_INFO_W-1:0] info;
    logic                  rs1_en;
    logic                  rs2_en;
    logic                  rd_en;
    logic [RFIDX_W-1:0]    rs1;
    logic [RFIDX_W-1:0]    rs2;
    logic [RFIDX_W-1:0]    rd;
  } disp_payload_t;

  function automatic logic [IDX_OH_W-1:0] idx_onehot(input logic [RFIDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xf100_exu_scbd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xf100_exu_scbd : pending-write scoreboard with 3-port hazard lookup
// Optional writeback bypass: XF100_DISP_WB_BYPASS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module xf100_exu_scbd
  import xf100_exu_disp_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en_i,
  input  logic [RFIDX_W-1:0] set_idx_i,
  input  logic               clr_en_i,
  input  logic [RFIDX_W-1:0] clr_idx_i,
  input  logic [RFIDX_W-1:0] rs1_idx_i,
  input  logic [RFIDX_W-1:0] rs2_idx_i,
  input  logic [RFIDX_W-1:0] rd_idx_i,
  output logic [2:0]         hit_o,
  output logic               any_pend_o
);

  localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [IDX_OH_W-1:0] set_oh_w, clr_oh_w, rs1_oh_w, rs2_oh_w, rd_oh_w;
  logic [NUM_REGS-1:0] pend_q, pend_d, pend_eff_w;

  assign set_oh_w = set_en_i ? idx_onehot(set_idx_i) : '0;
  assign clr_oh_w = clr_en_i ? idx_onehot(clr_idx_i) : '0;
  assign rs1_oh_w = idx_onehot(rs1_idx_i);
  assign rs2_oh_w = idx_onehot(rs2_idx_i);
  assign rd_oh_w  = idx_onehot(rd_idx_i);

  // Set is OR-ed after the clear so a same-index set/clear leaves the bit set.
  always_comb begin
    pend_d = ((pend_q & ~clr_oh_w[NUM_REGS-1:0]) | set_oh_w[NUM_REGS-1:0]) & X0_MASK;
  end

`ifdef XF100_DISP_WB_BYPASS_EN
  assign pend_eff_w = pend_q & X0_MASK & ~clr_oh_w[NUM_REGS-1:0];
`else
  assign pend_eff_w = pend_q & X0_MASK;
`endif

  assign hit_o[0]   = |(pend_eff_w & rs1_oh_w[NUM_REGS-1:0]);
  assign hit_o[1]   = |(pend_eff_w & rs2_oh_w[NUM_REGS-1:0]);
  assign hit_o[2]   = |(pend_eff_w & rd_oh_w[NUM_REGS-1:0]);
  assign any_pend_o = |pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule
`default_nettype wire

// File: rtl/xf100_exu_disp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xf100_exu_disp : one-slot dispatch stage with RAW/WAW hazard blocking
// Optional writeback bypass: XF100_DISP_WB_BYPASS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module xf100_exu_disp
  import xf100_exu_disp_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_alu_op,
  input  logic [ALU_INFO_W-1:0]  i_alu_info,
  input  logic                   i_rs1_en,
  input  logic                   i_rs2_en,
  input  logic                   i_rd_en,
  input  logic [RFIDX_W-1:0]     i_rs1_idx,
  input  logic [RFIDX_W-1:0]     i_rs2_idx,
  input  logic [RFIDX_W-1:0]     i_rd_idx,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [ALU_INFO_W-1:0]  o_alu_info,
  output logic [RFIDX_W-1:0]     o_rs1_idx,
  output logic [RFIDX_W-1:0]     o_rs2_idx,
  output logic [RFIDX_W-1:0]     o_rd_idx,
  output logic                   o_rd_en,
  input  logic                   wb_valid,
  input  logic [RFIDX_W-1:0]     wb_rd_idx,
  input  logic                   flush,
  output logic                   o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  disp_payload_t          pay_q, pay_d;
  logic                   disp_vld_q, disp_vld_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]             hit_w;
  logic                   hazard_w, fire_w, drop_w, capture_w, stall_w, any_pend_w, set_en_w;

  assign drop_w    = disp_vld_q & ~pay_q.alu_op;
  assign fire_w    = o_valid & o_ready;
  assign i_ready   = ~flush & (~disp_vld_q | fire_w | drop_w);
  assign capture_w = i_valid & i_ready;
  assign hazard_w  = (pay_q.rs1_en & hit_w[0]) | (pay_q.rs2_en & hit_w[1]) | (pay_q.rd_en & hit_w[2]);
  assign o_valid   = disp_vld_q & pay_q.alu_op & ~hazard_w & ~flush;
  assign stall_w   = disp_vld_q & pay_q.alu_op & hazard_w & ~flush;
  assign set_en_w  = fire_w & pay_q.rd_en & (pay_q.rd != '0);

  assign o_alu_info  = pay_q.info;
  assign o_rs1_idx   = pay_q.rs1;
  assign o_rs2_idx   = pay_q.rs2;
  assign o_rd_idx    = pay_q.rd;
  assign o_rd_en     = pay_q.rd_en;
  assign o_busy      = disp_vld_q | any_pend_w;
  assign o_stall_cnt = stall_cnt_q;

  always_comb begin
    disp_vld_d  = disp_vld_q;
    pay_d       = pay_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      disp_vld_d = 1'b0;
    end else if (capture_w) begin
      disp_vld_d   = 1'b1;
      pay_d.alu_op = i_alu_op;
      pay_d.info   = i_alu_info;
      pay_d.rs1_en = i_rs1_en;
      pay_d.rs2_en = i_rs2_en;
      pay_d.rd_en  = i_rd_en;
      pay_d.rs1    = i_rs1_idx;
      pay_d.rs2    = i_rs2_idx;
      pay_d.rd     = i_rd_idx;
    end else if (fire_w | drop_w) begin
      disp_vld_d = 1'b0;
    end
    if (stall_w && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_vld_q  <= 1'b0;
      pay_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      disp_vld_q  <= disp_vld_d;
      pay_q       <= pay_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  xf100_exu_scbd #(
    .NUM_REGS (NUM_REGS)
  ) u_scbd (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en_w),
    .set_idx_i  (pay_q.rd),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_rd_idx),
    .rs1_idx_i  (pay_q.rs1),
    .rs2_idx_i  (pay_q.rs2),
    .rd_idx_i   (pay_q.rd),
    .hit_o      (hit_w),
    .any_pend_o (any_pend_w)
  );

endmodule
`default_nettype wire

// File: tb/tb_xf100_exu_disp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_xf100_exu_disp : directed stimulus, queue scoreboard for dispatched ops
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_xf100_exu_disp;
  import xf100_exu_disp_pkg::*;

  localparam int IW = ALU_INFO_W;
  localparam int RW = RFIDX_W;
`ifdef XF100_DISP_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0, i_ready, i_alu_op = 1'b0;
  logic [IW-1:0] i_alu_info = '0;
  logic          i_rs1_en = 1'b0, i_rs2_en = 1'b0, i_rd_en = 1'b0;
  logic [RW-1:0] i_rs1_idx = '0, i_rs2_idx = '0, i_rd_idx = '0;
  logic          o_valid, o_ready = 1'b0;
  logic [IW-1:0] o_alu_info;
  logic [RW-1:0] o_rs1_idx, o_rs2_idx, o_rd_idx;
  logic          o_rd_en;
  logic          wb_valid = 1'b0;
  logic [RW-1:0] wb_rd_idx = '0;
  logic          flush = 1'b0;
  logic          o_busy;
  logic [15:0]   o_stall_cnt;

  always #5 clk = ~clk;

  xf100_exu_disp #(.NUM_REGS(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_alu_op(i_alu_op), .i_alu_info(i_alu_info),
    .i_rs1_en(i_rs1_en), .i_rs2_en(i_rs2_en), .i_rd_en(i_rd_en),
    .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
    .o_valid(o_valid), .o_ready(o_ready), .o_alu_info(o_alu_info),
    .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx), .o_rd_en(o_rd_en),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .flush(flush),
    .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct packed {
    logic [IW-1:0] info;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          rd_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, n_fire = 0, cyc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every handshake must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      exp_t e;
      n_fire++;
      check("dispatch_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dispatch_payload", {o_alu_info, o_rs1_idx, o_rs2_idx, o_rd_idx, o_rd_en}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic alu, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2);
    i_alu_op   = alu;
    i_alu_info = IW'(1) << rd[2:0];
    i_rs1_en   = 1'b1;
    i_rs2_en   = 1'b1;
    i_rd_en    = 1'b1;
    i_rs1_idx  = rs1;
    i_rs2_idx  = rs2;
    i_rd_idx   = rd;
  endtask

  // Returns one step after the capture edge.
  task automatic issue(input logic alu, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input bit push);
    int g = 0;
    drive(alu, rd, rs1, rs2);
    i_valid = 1'b1;
    while (!i_ready && g < 50) begin
      tick();
      g++;
    end
    if (g == 50) check("issue_accept_timeout", i_ready, 1);
    if (push) exp_q.push_back({i_alu_info, rs1, rs2, rd, 1'b1});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic writeback(input logic [RW-1:0] r);
    wb_valid  = 1'b1;
    wb_rd_idx = r;
    tick();
    wb_valid  = 1'b0;
  endtask

  initial begin
    int c0, f0, s0, g;

    // reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_i_ready", i_ready, 1);
    check("rst_stall_cnt", o_stall_cnt, 0);
    tick();
    rst = 1'b0;
    o_ready = 1'b1;
    tick();

    // RAW stall on x3, released by writeback
    f0 = n_fire;
    issue(1'b1, 5'd3, 5'd1, 5'd2, 1'b1);
    issue(1'b1, 5'd4, 5'd3, 5'd0, 1'b1);
    repeat (5) tick();
    wb_valid  = 1'b1;
    wb_rd_idx = 5'd3;
    @(negedge clk);
    check("raw_stall_cnt", o_stall_cnt, 5);
    check("raw_o_valid_wb_cycle", o_valid, BYP);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_o_valid_after_wb", o_valid, !BYP);
    tick();
    check("raw_stall_cnt_final", o_stall_cnt, BYP ? 5 : 6);
    check("raw_fires", n_fire - f0, 2);
    check("raw_pend_x4", dut.u_scbd.pend_q, 32'h10);
    writeback(5'd4);
    @(negedge clk);
    check("raw_busy_clear", o_busy, 0);
    tick();

    // 8 independent ADDs at full throughput
    c0 = cyc_cnt;
    f0 = n_fire;
    for (int i = 0; i < 8; i++) issue(1'b1, RW'(5 + i), 5'd1, 5'd2, 1'b1);
    tick();
    check("burst_cycles", cyc_cnt - c0, 9);
    check("burst_fires", n_fire - f0, 8);
    check("burst_pend", dut.u_scbd.pend_q, 32'h1FE0);
    for (int r = 5; r <= 12; r++) writeback(RW'(r));
    @(negedge clk);
    check("burst_busy_clear", o_busy, 0);
    tick();

    // x0 never stalls and never becomes pending
    s0 = o_stall_cnt;
    f0 = n_fire;
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    check("x0_stall_cnt", o_stall_cnt, s0);
    check("x0_fires", n_fire - f0, 2);
    check("x0_busy", o_busy, 0);

    // non-ALU op is dropped, never presented
    issue(1'b0, 5'd5, 5'd1, 5'd2, 1'b0);
    @(negedge clk);
    check("drop_o_valid", o_valid, 0);
    check("drop_i_ready", i_ready, 1);
    tick();
    @(negedge clk);
    check("drop_busy", o_busy, 0);
    tick();

    // flush of a held instruction leaves pending bits alone
    issue(1'b1, 5'd9, 5'd1, 5'd2, 1'b1);
    tick();
    o_ready = 1'b0;
    issue(1'b1, 5'd6, 5'd1, 5'd2, 1'b0);
    @(negedge clk);
    check("hold_o_valid", o_valid, 1);
    tick();
    @(negedge clk);
    check("hold_o_valid_2", o_valid, 1);
    check("hold_rd_idx", o_rd_idx, 6);
    tick();
    flush = 1'b1;
    o_ready = 1'b1;
    drive(1'b1, 5'd11, 5'd1, 5'd2);
    i_valid = 1'b1;
    @(negedge clk);
    check("flush_o_valid", o_valid, 0);
    check("flush_i_ready", i_ready, 0);
    tick();
    flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("flush_disp_vld", dut.disp_vld_q, 0);
    check("flush_o_valid_after", o_valid, 0);
    check("flush_pend", dut.u_scbd.pend_q, 32'h200);
    check("flush_busy", o_busy, 1);
    tick();
    tick();
    writeback(5'd9);
    @(negedge clk);
    check("flush_busy_clear", o_busy, 0);
    tick();

    // same-cycle set and clear of x7: set wins
    issue(1'b1, 5'd7, 5'd1, 5'd2, 1'b1);
    writeback(5'd7);
    check("setwins_pend", dut.u_scbd.pend_q, 32'h80);
    writeback(5'd7);
    check("setwins_cleared", dut.u_scbd.pend_q, 32'h0);

    // saturate the stall counter, then async reset mid-stall
    issue(1'b1, 5'd10, 5'd1, 5'd2, 1'b1);
    tick();
    issue(1'b1, 5'd11, 5'd10, 5'd2, 1'b0);
    g = 0;
    while (o_stall_cnt != 16'hFFFF && g < 70000) begin
      tick();
      g++;
    end
    check("sat_reached", o_stall_cnt, 16'hFFFF);
    repeat (3) tick();
    check("sat_hold", o_stall_cnt, 16'hFFFF);
    check("sat_o_valid", o_valid, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_o_busy", o_busy, 0);
    check("arst_stall_cnt", o_stall_cnt, 0);
    check("arst_i_ready", i_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xf100_exu_disp.md
# xf100_exu_disp

Dispatch controller sitting between `xf100_exu_decode` and the ALU. It holds one decoded instruction in a staging register and tracks outstanding register writes in a 32-entry scoreboard. Dispatch to the ALU over a valid/ready handshake is blocked on RAW/WAW hazards until the matching writeback arrives. It also flushes the staged slot on request and keeps a saturating stall counter.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked; bit 0 never pending
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  decoded instruction valid
- i_ready  out  1  staging slot can accept
- i_alu_op  in  1  instruction is an ALU op
- i_alu_info  in  `ALU_INFO_WIDTH  ALU operation one-hot
- i_rs1_en, i_rs2_en, i_rd_en  in  1 each  operand/destination enables
- i_rs1_idx, i_rs2_idx, i_rd_idx  in  `XF100_RFIDX_WIDTH each  register indices
- o_valid  out  1  instruction issued to ALU
- o_ready  in  1  ALU accepts
- o_alu_info  out  `ALU_INFO_WIDTH  staged ALU info
- o_rs1_idx, o_rs2_idx, o_rd_idx  out  `XF100_RFIDX_WIDTH each  staged indices
- o_rd_en  out  1  staged rd enable
- wb_valid  in  1  writeback completes
- wb_rd_idx  in  `XF100_RFIDX_WIDTH  register written back
- flush  in  1  discard staged instruction
- o_busy  out  1  staged valid or any pending bit set
- o_stall_cnt  out  STALL_CNT_W  hazard-stall cycle count

## Operation
- Staging register `disp_vld` plus payload. Payload is captured on `i_valid & i_ready`.
- `i_ready = ~flush & (~disp_vld | fire | drop)`, where `fire = o_valid & o_ready`.
- `drop = disp_vld & ~i_alu_op_q`: a non-ALU instruction is discarded one cycle after capture and is never presented.
- Effective pending vector `pend_eff`:
  - `pend` with bit 0 forced to 0.
  - Under the bypass macro, also masked by the one-hot of `wb_rd_idx` when `wb_valid` is high.
- `hazard = (rs1_en_q & pend_eff[rs1]) | (rs2_en_q & pend_eff[rs2]) | (rd_en_q & pend_eff[rd])`. The rd term covers WAW.
- `o_valid = disp_vld & i_alu_op_q & ~hazard & ~flush`. Payload outputs are driven straight from the staging register.
- Scoreboard update each cycle:
  - `fire & rd_en_q & rd != 0` sets `pend[rd]`.
  - `wb_valid` clears `pend[wb_rd_idx]`.
  - Set and clear on the same index in the same cycle: set wins.
  - Clear of a non-pending index: no effect.
- `flush` clears `disp_vld` next cycle. `pend` is untouched, because in-flight ops still write back.
- `o_stall_cnt` increments in every cycle where `disp_vld & i_alu_op_q & hazard & ~flush`. It saturates at all-ones and is cleared only by reset.
- `o_busy = disp_vld | (|pend)`.

## Timing
- Reset values: `disp_vld`=0, payload=0, `pend`=0, `o_stall_cnt`=0. Hence `o_valid`=0, `o_busy`=0, and `i_ready`=1 whenever `flush`=0.
- Capture to `o_valid`: 1 cycle minimum. Throughput is 1 instruction/cycle with no hazards, since `i_ready` stays high while `fire` is high.
- A dispatched rd becomes pending from the next cycle. A back-to-back dependent instruction therefore stalls.
- `o_valid` may drop while waiting on a hazard. Once asserted, `o_valid` and the payload are held until `o_ready` or `flush`.
- `flush` together with `i_valid`: nothing is captured. `flush` together with `o_ready`: no fire.
- Reset asserted mid-operation clears all state immediately (async). Pending writebacks are lost.

## Configuration
- `XF100_DISP_WB_BYPASS_EN` defined: a writeback in cycle N unblocks a dependent staged instruction in cycle N (combinational `wb` → `o_valid` path).
- Not defined: the unblock happens in cycle N+1, and there is no `wb` → `o_valid` combinational path.

## Structure
- Shared defines file: `XF100_RFIDX_WIDTH`, `ALU_INFO_WIDTH`, and new `XF100_NUM_REGS`.
- Sub-module `xf100_exu_scbd` contains:
  - the pending vector
  - set/clear logic and set-wins priority
  - bypass masking
  - a 3-port lookup returning the hazard bits

## Test plan
- ADD x3←x1,x2, then ADD x4←x3,x0, no wb → second holds `o_valid`=0 and `o_stall_cnt` counts; `wb_valid`, `wb_rd_idx`=3 at cycle N → dispatch at N (macro on) or N+1 (macro off).
- 8 independent ADDs with rd=x5..x12, `o_ready`=1 → one dispatch per cycle, `pend`=0x1FE0 afterwards.
- rd=x0 and rs=x0 instructions → never stall, `pend` bit 0 stays 0.
- Staged instruction with `o_ready`=0, `flush`=1 → next cycle `disp_vld`=0, no dispatch, `pend` unchanged, `o_busy` reflects `pend` only.
- Same-cycle dispatch setting x7 and wb clearing x7 (macro on) → `pend[7]`=1.
- Force 65535 hazard cycles → `o_stall_cnt`=0xFFFF and holds; async `rst` mid-stall → all outputs at reset values without a clock edge.
